// File: rtl/ame_transpose_buffer.sv
// Ping-pong N x N pixel block buffer: rows written in, each block read out as rows or columns.
// Define AME_TRANSPOSE_BUFFER_DOUBLE_BANK_EN for two banks; the default build holds one bank.
module ame_transpose_buffer #(
    parameter int PIX_WIDTH = 8,
    parameter int N         = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [N*PIX_WIDTH-1:0] wr_data_i,
    input  logic                   rd_mode_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [N*PIX_WIDTH-1:0] rd_data_o,
    output logic [$clog2(N)-1:0]   rd_idx_o,
    output logic                   rd_last_o
);
    localparam int CW = $clog2(N);
    localparam int RW = N * PIX_WIDTH;
`ifdef AME_TRANSPOSE_BUFFER_DOUBLE_BANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t   bank_state     [NB];
    bank_state_t   bank_state_nxt [NB];
    logic [RW-1:0] mem            [NB][N];

    logic          wr_ptr;
    logic          rd_ptr;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          rd_mode_q;

    logic          wr_fire;
    logic          wr_last;
    logic          out_free;
    logic          rd_avail;
    logic          rd_load;
    logic          rd_last_beat;
    logic          beat_mode;
    logic [RW-1:0] beat_data;

    assign wr_ready_o   = (bank_state[wr_ptr] == BANK_EMPTY) || (bank_state[wr_ptr] == BANK_FILLING);
    assign wr_fire      = wr_valid_i && wr_ready_o && !flush_i;
    assign wr_last      = (wr_cnt == CW'(N - 1));
    assign out_free     = !rd_valid_o || rd_ready_i;
    assign rd_avail     = (bank_state[rd_ptr] == BANK_FULL) || (bank_state[rd_ptr] == BANK_DRAINING);
    assign rd_load      = out_free && rd_avail && !flush_i;
    assign rd_last_beat = (rd_cnt == CW'(N - 1));
    // The transpose choice is taken live on beat 0 and frozen for the rest of the block.
    assign beat_mode    = (rd_cnt == '0) ? rd_mode_i : rd_mode_q;

    // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        for (int b = 0; b < NB; b++) bank_state_nxt[b] = bank_state[b];
        if (flush_i) begin
            for (int b = 0; b < NB; b++) bank_state_nxt[b] = BANK_EMPTY;
        end else begin
            if (wr_fire) bank_state_nxt[wr_ptr] = wr_last ? BANK_FULL : BANK_FILLING;
            if (rd_load) bank_state_nxt[rd_ptr] = rd_last_beat ? BANK_EMPTY : BANK_DRAINING;
        end
    end

    // NOTE: state flops use non-blocking assignments; blocking ones belong only in always_comb.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < NB; b++) bank_state[b] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < NB; b++) bank_state[b] <= bank_state_nxt[b];
        end
    end

`ifdef AME_TRANSPOSE_BUFFER_DOUBLE_BANK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_fire && wr_last)      wr_ptr <= ~wr_ptr;
            if (rd_load && rd_last_beat) rd_ptr <= ~rd_ptr;
        end
    end
`else
    assign wr_ptr = 1'b0;
    assign rd_ptr = 1'b0;
`endif

    // NOTE: the pixel array has no reset; bank state alone says whether its contents are live.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem[wr_ptr][wr_cnt] <= wr_data_i;
    end

    always_comb begin
        beat_data = mem[rd_ptr][rd_cnt];
        if (beat_mode) begin
            for (int r = 0; r < N; r++)
                beat_data[r*PIX_WIDTH +: PIX_WIDTH] = mem[rd_ptr][CW'(r)][int'(rd_cnt)*PIX_WIDTH +: PIX_WIDTH];
        end
    end

    // Counters wrap naturally because N is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_mode_q  <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            rd_idx_o   <= '0;
            rd_last_o  <= 1'b0;
        end else if (flush_i) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_mode_q  <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_idx_o   <= '0;
            rd_last_o  <= 1'b0;
        end else begin
            if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
            if (rd_load) begin
                rd_valid_o <= 1'b1;
                rd_data_o  <= beat_data;
                rd_idx_o   <= rd_cnt;
                rd_last_o  <= rd_last_beat;
                rd_cnt     <= rd_cnt + 1'b1;
                if (rd_cnt == '0) rd_mode_q <= rd_mode_i;
            end else if (out_free) begin
                rd_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ame_transpose_buffer.sv
// Self-checking bench for ame_transpose_buffer (N=4, 8-bit pixels) against a queue-based block model.
module tb_ame_transpose_buffer;
    localparam int PW = 8;
    localparam int N  = 4;
    localparam int RW = N * PW;
    localparam int CW = $clog2(N);
`ifdef AME_TRANSPOSE_BUFFER_DOUBLE_BANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [N*RW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [RW-1:0] wr_data;
    logic          rd_mode;
    logic          rd_valid;
    logic          rd_ready;
    logic [RW-1:0] rd_data;
    logic [CW-1:0] rd_idx;
    logic          rd_last;

    always #5 clk = ~clk;

    ame_transpose_buffer #(.PIX_WIDTH(PW), .N(N)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_data_i  (wr_data),
        .rd_mode_i  (rd_mode),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .rd_idx_o   (rd_idx),
        .rd_last_o  (rd_last)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: queue of complete blocks awaiting release, plus the output beat.
    blk_t          avail [$];
    blk_t          part;
    int            m_rows;
    int            m_bcnt;
    logic          m_valid;
    logic          m_last;
    logic          m_mode;
    logic          m_wr_ready;
    logic [RW-1:0] m_data;
    logic [CW-1:0] m_idx;

    function automatic logic [RW-1:0] beat_of(blk_t b, logic col, int k);
        logic [RW-1:0] res;
        res = b[k*RW +: RW];
        if (col) begin
            for (int r = 0; r < N; r++) res[r*PW +: PW] = b[r*RW + k*PW +: PW];
        end
        return res;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < N * N; i++) b[i*PW +: PW] = PW'($urandom);
        return b;
    endfunction

    function automatic blk_t pattern_blk();
        blk_t b;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) b[r*RW + c*PW +: PW] = PW'(16 * r + c);
        return b;
    endfunction

    task automatic model_reset();
        avail.delete();
        part       = '0;
        m_rows     = 0;
        m_bcnt     = 0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_mode     = 1'b0;
        m_data     = '0;
        m_idx      = '0;
        m_wr_ready = 1'b1;
    endtask

    task automatic step();
        logic          wr_fire;
        logic          out_free;
        logic          mode_in;
        logic          flush_in;
        logic          mode;
        logic [RW-1:0] data_in;
        wr_fire  = wr_valid && m_wr_ready;
        out_free = !m_valid || rd_ready;
        mode_in  = rd_mode;
        flush_in = flush;
        data_in  = wr_data;
        @(posedge clk);
        #1;
        if (flush_in) begin
            avail.delete();
            m_rows  = 0;
            m_bcnt  = 0;
            m_valid = 1'b0;
            m_idx   = '0;
            m_last  = 1'b0;
            m_mode  = 1'b0;
        end else begin
            if (out_free && avail.size() > 0) begin
                mode    = (m_bcnt == 0) ? mode_in : m_mode;
                m_mode  = mode;
                m_data  = beat_of(avail[0], mode, m_bcnt);
                m_idx   = CW'(m_bcnt);
                m_last  = (m_bcnt == N - 1);
                m_valid = 1'b1;
                if (m_bcnt == N - 1) begin
                    void'(avail.pop_front());
                    m_bcnt = 0;
                end else begin
                    m_bcnt++;
                end
            end else if (out_free) begin
                m_valid = 1'b0;
            end
            if (wr_fire) begin
                part[m_rows*RW +: RW] = data_in;
                m_rows++;
                if (m_rows == N) begin
                    avail.push_back(part);
                    m_rows = 0;
                end
            end
        end
        m_wr_ready = (avail.size() < NB);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_mode = 1'b0; rd_ready = 1'b0;
        model_reset();
        #2;
        n_total++;
        if ({wr_ready, rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, 1'b0, {RW{1'b0}}, {CW{1'b0}}, 1'b0})
            $display("FAIL reset_values: got rdy=%0b v=%0b d=%h i=%0d l=%0b want 1/0/0/0/0",
                     wr_ready, rd_valid, rd_data, rd_idx, rd_last);
        else n_pass++;
        #4 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_total++;
            if (rd_valid !== 1'b0 || wr_ready !== 1'b1)
                $display("FAIL reset_idle c%0d: got v=%0b rdy=%0b want 0/1", c, rd_valid, wr_ready);
            else n_pass++;
        end
    endtask

    task automatic test_pattern_block(input logic mode);
        blk_t          b;
        int            first_v;
        int            nb;
        logic [RW-1:0] exp_beat [N];
        logic [RW-1:0] got      [N];
        logic [CW-1:0] gidx     [N];
        logic          glast    [N];
        if (!mode) exp_beat = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
        else       exp_beat = '{32'h30201000, 32'h31211101, 32'h32221202, 32'h33231303};
        b = pattern_blk();
        first_v = -1;
        nb = 0;
        rd_mode = mode;
        rd_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            wr_valid = (c < N);
            if (c < N) wr_data = b[c*RW +: RW];
            step();
            n_total++;
            if (rd_valid !== m_valid || wr_ready !== m_wr_ready)
                $display("FAIL pattern%0b c%0d valid/ready: got %0b/%0b want %0b/%0b",
                         mode, c, rd_valid, wr_ready, m_valid, m_wr_ready);
            else n_pass++;
            if (rd_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                if (nb < N) begin
                    got[nb] = rd_data; gidx[nb] = rd_idx; glast[nb] = rd_last;
                end
                nb++;
            end
        end
        wr_valid = 1'b0;
        n_total++;
        if (first_v != N) $display("FAIL pattern%0b latency: got first valid at step %0d want %0d", mode, first_v, N);
        else n_pass++;
        n_total++;
        if (nb != N) $display("FAIL pattern%0b beat_count: got %0d want %0d", mode, nb, N);
        else n_pass++;
        for (int k = 0; k < N && k < nb; k++) begin
            n_total++;
            if ({got[k], gidx[k], glast[k]} !== {exp_beat[k], CW'(k), (k == N - 1)})
                $display("FAIL pattern%0b beat%0d: got %h/%0d/%0b want %h/%0d/%0b",
                         mode, k, got[k], gidx[k], glast[k], exp_beat[k], k, (k == N - 1));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        blk_t blks [3];
        int   rows_sent;
        int   hs;
        logic seen_rel;
        logic prev_rdy;
        logic acc;
        for (int i = 0; i < 3; i++) blks[i] = rand_blk();
        rows_sent = 0; hs = 0; seen_rel = 1'b0; prev_rdy = wr_ready;
        for (int c = 0; c < 70; c++) begin
            wr_valid = (rows_sent < 3 * N);
            if (wr_valid) wr_data = blks[rows_sent / N][(rows_sent % N)*RW +: RW];
            rd_ready = (c >= 20);
            rd_mode  = 1'($urandom);
            acc = wr_valid && m_wr_ready;
            if (rd_valid && rd_ready) hs++;
            prev_rdy = wr_ready;
            step();
            if (acc) rows_sent++;
            n_total++;
            if (rd_valid !== m_valid || wr_ready !== m_wr_ready)
                $display("FAIL b2b c%0d valid/ready: got %0b/%0b want %0b/%0b", c, rd_valid, wr_ready, m_valid, m_wr_ready);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if ({rd_data, rd_idx, rd_last} !== {m_data, m_idx, m_last})
                    $display("FAIL b2b c%0d beat: got %h/%0d/%0b want %h/%0d/%0b",
                             c, rd_data, rd_idx, rd_last, m_data, m_idx, m_last);
                else n_pass++;
            end
            if (c == 19) begin
                n_total++;
                if (rows_sent != NB * N || wr_ready !== 1'b0)
                    $display("FAIL b2b stall_fill: got rows=%0d rdy=%0b want %0d/0", rows_sent, wr_ready, NB * N);
                else n_pass++;
            end
            if (c >= 20 && !seen_rel && rd_valid === 1'b1 && rd_idx == CW'(N - 1)) begin
                seen_rel = 1'b1;
                n_total++;
                if (wr_ready !== 1'b1 || prev_rdy !== 1'b0)
                    $display("FAIL b2b release: got rdy before/after %0b/%0b want 0/1", prev_rdy, wr_ready);
                else n_pass++;
            end
        end
        wr_valid = 1'b0;
        n_total++;
        if (hs != 3 * N || rows_sent != 3 * N || !seen_rel)
            $display("FAIL b2b totals: got beats=%0d rows=%0d rel=%0b want %0d/%0d/1", hs, rows_sent, seen_rel, 3 * N, 3 * N);
        else n_pass++;
    endtask

    task automatic test_stall();
        blk_t          blks [2];
        logic          pat  [4];
        int            rows_sent;
        int            hs;
        logic          stalled;
        logic          acc;
        logic [RW-1:0] hold_d;
        logic [CW-1:0] hold_i;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 2; i++) blks[i] = rand_blk();
        rows_sent = 0; hs = 0;
        for (int c = 0; c < 48; c++) begin
            wr_valid = (rows_sent < 2 * N);
            if (wr_valid) wr_data = blks[rows_sent / N][(rows_sent % N)*RW +: RW];
            rd_ready = pat[c % 4];
            rd_mode  = 1'($urandom);
            acc = wr_valid && m_wr_ready;
            stalled = m_valid && !rd_ready;
            hold_d = m_data;
            hold_i = m_idx;
            if (m_valid && rd_ready) begin
                n_total++;
                if (rd_idx !== CW'(hs % N))
                    $display("FAIL stall c%0d handshake_idx: got %0d want %0d", c, rd_idx, hs % N);
                else n_pass++;
                hs++;
            end
            step();
            if (acc) rows_sent++;
            n_total++;
            if (rd_valid !== m_valid || wr_ready !== m_wr_ready)
                $display("FAIL stall c%0d valid/ready: got %0b/%0b want %0b/%0b", c, rd_valid, wr_ready, m_valid, m_wr_ready);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if ({rd_data, rd_idx, rd_last} !== {m_data, m_idx, m_last})
                    $display("FAIL stall c%0d beat: got %h/%0d/%0b want %h/%0d/%0b",
                             c, rd_data, rd_idx, rd_last, m_data, m_idx, m_last);
                else n_pass++;
            end
            if (stalled) begin
                n_total++;
                if (rd_data !== hold_d || rd_idx !== hold_i)
                    $display("FAIL stall c%0d hold: got %h/%0d want %h/%0d", c, rd_data, rd_idx, hold_d, hold_i);
                else n_pass++;
            end
        end
        wr_valid = 1'b0;
        n_total++;
        if (hs != 2 * N) $display("FAIL stall handshakes: got %0d want %0d", hs, 2 * N);
        else n_pass++;
    endtask

    task automatic test_flush();
        blk_t          blks [2];
        blk_t          fresh;
        int            rows_sent;
        int            nb;
        logic          acc;
        logic [RW-1:0] data_before;
        for (int i = 0; i < 2; i++) blks[i] = rand_blk();
        fresh = rand_blk();
        rows_sent = 0;
        rd_ready = 1'b1;
        data_before = '0;
        for (int c = 0; c < 7; c++) begin
            wr_valid = (rows_sent < N + 2);
            if (wr_valid) wr_data = blks[rows_sent / N][(rows_sent % N)*RW +: RW];
            rd_mode = 1'($urandom);
            flush = (c == 6);
            acc = wr_valid && m_wr_ready && !flush;
            if (flush) data_before = rd_data;
            step();
            if (acc) rows_sent++;
        end
        flush = 1'b0;
        wr_valid = 1'b0;
        n_total++;
        if ({rd_valid, wr_ready, rd_idx, rd_last} !== {1'b0, 1'b1, {CW{1'b0}}, 1'b0})
            $display("FAIL flush_state: got v=%0b rdy=%0b i=%0d l=%0b want 0/1/0/0", rd_valid, wr_ready, rd_idx, rd_last);
        else n_pass++;
        n_total++;
        if (rd_data !== data_before) $display("FAIL flush_data_hold: got %h want %h", rd_data, data_before);
        else n_pass++;
        rows_sent = 0; nb = 0;
        for (int c = 0; c < 16; c++) begin
            wr_valid = (rows_sent < N);
            if (wr_valid) wr_data = fresh[rows_sent*RW +: RW];
            rd_mode = 1'($urandom);
            acc = wr_valid && m_wr_ready;
            step();
            if (acc) rows_sent++;
            if (rd_valid === 1'b1) nb++;
            n_total++;
            if (rd_valid !== m_valid || wr_ready !== m_wr_ready)
                $display("FAIL flush c%0d valid/ready: got %0b/%0b want %0b/%0b", c, rd_valid, wr_ready, m_valid, m_wr_ready);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if ({rd_data, rd_idx, rd_last} !== {m_data, m_idx, m_last})
                    $display("FAIL flush c%0d beat: got %h/%0d/%0b want %h/%0d/%0b",
                             c, rd_data, rd_idx, rd_last, m_data, m_idx, m_last);
                else n_pass++;
            end
        end
        wr_valid = 1'b0;
        n_total++;
        if (nb != N) $display("FAIL flush fresh_beats: got %0d want %0d", nb, N);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        blk_t blks [2];
        blk_t fresh;
        int   rows_sent;
        int   nb;
        logic acc;
        for (int i = 0; i < 2; i++) blks[i] = rand_blk();
        fresh = rand_blk();
        rows_sent = 0;
        rd_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            wr_valid = (rows_sent < N + 2);
            if (wr_valid) wr_data = blks[rows_sent / N][(rows_sent % N)*RW +: RW];
            rd_mode = 1'($urandom);
            acc = wr_valid && m_wr_ready;
            step();
            if (acc) rows_sent++;
        end
        wr_valid = 1'b0;
        n_total++;
        if (rd_valid !== 1'b1) $display("FAIL areset pre_valid: got %0b want 1", rd_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({wr_ready, rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, 1'b0, {RW{1'b0}}, {CW{1'b0}}, 1'b0})
            $display("FAIL areset values: got rdy=%0b v=%0b d=%h i=%0d l=%0b want 1/0/0/0/0",
                     wr_ready, rd_valid, rd_data, rd_idx, rd_last);
        else n_pass++;
        #1 rst_n = 1'b1;
        model_reset();
        rows_sent = 0; nb = 0;
        rd_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            wr_valid = (c < N - 1 || (c >= 8 && rows_sent < N));
            if (wr_valid) wr_data = fresh[rows_sent*RW +: RW];
            rd_mode = 1'($urandom);
            acc = wr_valid && m_wr_ready;
            step();
            if (acc) rows_sent++;
            if (rd_valid === 1'b1) nb++;
            n_total++;
            if (rd_valid !== m_valid || wr_ready !== m_wr_ready)
                $display("FAIL areset c%0d valid/ready: got %0b/%0b want %0b/%0b", c, rd_valid, wr_ready, m_valid, m_wr_ready);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if ({rd_data, rd_idx, rd_last} !== {m_data, m_idx, m_last})
                    $display("FAIL areset c%0d beat: got %h/%0d/%0b want %h/%0d/%0b",
                             c, rd_data, rd_idx, rd_last, m_data, m_idx, m_last);
                else n_pass++;
            end
        end
        wr_valid = 1'b0;
        n_total++;
        if (nb != N) $display("FAIL areset fresh_beats: got %0d want %0d", nb, N);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pattern_block(1'b0);
        test_pattern_block(1'b1);
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
